bus_sequencer: RTL and testbench
================================

BUS_SEQUENCER -- requirements
Module: bus_sequencer

Interface
REQ-001 SHALL have ports: clock  input  1  system clock; all state changes on posedge.
REQ-002 SHALL have: reset  input  1  asynchronous, active-high; one clock domain only.
REQ-003 SHALL have: hold  input  1  stall request, sampled in X3.
REQ-004 SHALL have: io_op  input  1  decoder flag, upper opcode nibble is I/O class, sampled in M1.
REQ-005 SHALL have: src_op  input  1  decoder flag, instruction is SRC, sampled in M2.
REQ-006 SHALL have: two_word  input  1  decoder flag, instruction has a second ROM word, sampled in M2.
REQ-007 SHALL have: dcl_write  input  1  DCL executing, sampled in X2.
REQ-008 SHALL have: dcl_value  input  3  DCL bank code, sampled with dcl_write.
REQ-009 SHALL have: phase  output  3  current phase, 0..7 = A1,A2,A3,M1,M2,X1,X2,X3.
REQ-010 SHALL have: sync  output  1  high during X3, marks the next cycle start.
REQ-011 SHALL have: addr_oe  output  1  CPU drives address nibble, high in A1..A3.
REQ-012 SHALL have: ir_hi_load, ir_lo_load  output  1 each  instruction nibble strobes, high in M1 and M2 respectively.
REQ-013 SHALL have: pc_inc  output  1  one-cycle pulse in A3.
REQ-014 SHALL have: second_word  output  1  current instruction cycle fetches a second word.
REQ-015 SHALL have: exec_en  output  1  high in X1..X3 when second_word=0.
REQ-016 SHALL have: cm_rom  output  1  ROM command line.
REQ-017 SHALL have: cm_ram  output  4  RAM bank command lines.

Function
REQ-018 phase SHALL advance by 1 each clock, wrapping X3->A1, except as in REQ-019.
REQ-019 If hold=1 while phase=X3, phase SHALL remain X3 with sync=1; advance to A1 on the first clock with hold=0.
REQ-020 All outputs SHALL be registered or decoded solely from registered state; no combinational path from any input to any output.
REQ-021 io_op SHALL be latched at end of M1, src_op and two_word at end of M2; latches SHALL clear at end of X3 unless held.
REQ-022 When two_word is latched =1 and second_word=0, second_word SHALL be 1 for the whole following instruction cycle (A1..X3), then return to 0.
REQ-023 During a second_word cycle io_op, src_op and two_word SHALL be ignored (latched as 0); dcl_write SHALL be ignored.
REQ-024 Bank register SHALL map code c to cm_ram pattern: c=0 -> 4'b0001, else {c,1'b0} (1->0010, 3->0110, 7->1110).
REQ-025 Bank register SHALL update at end of X2 when dcl_write=1 and second_word=0; new pattern used from the next A3.
REQ-026 cm_rom=1 and cm_ram=bank pattern SHALL assert in A3 of every cycle.
REQ-027 cm_rom=1 and cm_ram=bank pattern SHALL assert in M2 when io_op latched.
REQ-028 cm_rom=1 and cm_ram=bank pattern SHALL assert in X2 when src_op latched.
REQ-029 In all other phases cm_rom=0, cm_ram=4'b0000.
REQ-030 pc_inc SHALL pulse exactly once per instruction cycle, including second_word cycles and none while held in X3.

Reset
REQ-031 reset SHALL asynchronously force: phase=A1, sync=0, addr_oe=1, ir_hi_load=0, ir_lo_load=0, pc_inc=0, second_word=0, exec_en=0, cm_rom=0, cm_ram=0000, bank code=0, all flag latches=0.
REQ-032 Reset asserted mid-cycle or mid-second-word SHALL abandon the cycle; first clock after release SHALL advance to A2.
REQ-033 Only reset SHALL clear the bank register.

Verification
REQ-034 Reset release, all inputs 0, 16 clocks -> phase sequence 0..7,0..7; sync high exactly at clocks 7 and 15; pc_inc twice; cm_rom high only in A3.
REQ-035 two_word=1 in M2 -> next cycle second_word=1, exec_en=0 throughout; io_op=1 in that cycle's M1 -> no cm_rom in M2; following cycle second_word=0.
REQ-036 dcl_write=1, dcl_value=3 in X2 -> next A3 cm_ram=0110; src_op=1 in following M2 -> X2 cm_rom=1, cm_ram=0110; dcl_value=0 later -> 0001.
REQ-037 hold=1 for 5 clocks at X3 -> phase stays 7, sync=1 for 6 clocks total, no pc_inc; release -> A1 next clock.
REQ-038 Reset pulse in M2 with two_word=1 -> all outputs to REQ-031 values immediately; next cycle second_word=0, bank stays 0001.

Source files
------------

// File: rtl/bus_sequencer.sv
// bus_sequencer
//   Eight-phase instruction cycle sequencer (A1,A2,A3,M1,M2,X1,X2,X3) for a
//   nibble-serial CPU bus. Latches decoder flags at fixed phases, tracks
//   two-word instructions, holds the DCL bank code and drives the
//   ROM/RAM command lines.
//
// Ports
//   clock        in   system clock, all state changes on posedge
//   reset        in   asynchronous active-high reset
//   hold         in   stall request, sampled in X3
//   io_op        in   decoder flag (I/O class opcode), sampled in M1
//   src_op       in   decoder flag (SRC instruction), sampled in M2
//   two_word     in   decoder flag (second ROM word), sampled in M2
//   dcl_write    in   DCL executing, sampled in X2
//   dcl_value    in   [2:0] DCL bank code, sampled with dcl_write
//   phase        out  [2:0] current phase 0..7
//   sync         out  high during X3
//   addr_oe      out  high in A1..A3
//   ir_hi_load   out  high in M1
//   ir_lo_load   out  high in M2
//   pc_inc       out  one-cycle pulse in A3
//   second_word  out  current cycle fetches a second word
//   exec_en      out  high in X1..X3 of a normal (first-word) cycle
//   cm_rom       out  ROM command line
//   cm_ram       out  [3:0] RAM bank command lines
module bus_sequencer (
  input  logic       clock,
  input  logic       reset,
  input  logic       hold,
  input  logic       io_op,
  input  logic       src_op,
  input  logic       two_word,
  input  logic       dcl_write,
  input  logic [2:0] dcl_value,
  output logic [2:0] phase,
  output logic       sync,
  output logic       addr_oe,
  output logic       ir_hi_load,
  output logic       ir_lo_load,
  output logic       pc_inc,
  output logic       second_word,
  output logic       exec_en,
  output logic       cm_rom,
  output logic [3:0] cm_ram
);

  typedef enum logic [2:0] {
    A1 = 3'd0, A2 = 3'd1, A3 = 3'd2, M1 = 3'd3,
    M2 = 3'd4, X1 = 3'd5, X2 = 3'd6, X3 = 3'd7
  } phase_t;

  phase_t     phase_reg, phase_next;
  logic       sw_reg, sw_next;
  logic       io_reg, io_next;
  logic       src_reg, src_next;
  logic       tw_reg, tw_next;
  logic [2:0] bank_reg, bank_next;

  logic       sync_reg, addr_oe_reg, ir_hi_reg, ir_lo_reg, pc_inc_reg;
  logic       exec_en_reg, cm_rom_reg;
  logic [3:0] cm_ram_reg;

  logic       cmd_next;

  // Bank code 0 selects bank line 0; any other code is driven shifted up
  // one line so that line 0 stays reserved for the default bank.
  function automatic logic [3:0] bank_pattern(input logic [2:0] code);
    return (code == 3'd0) ? 4'b0001 : {code, 1'b0};
  endfunction

  // Next-state logic. Outputs are registered from the next-state values so
  // they line up with the phase they describe without any input-to-output
  // combinational path.
  always_comb begin
    phase_next = (phase_reg == X3 && hold) ? X3 : phase_t'(phase_reg + 3'd1);
    sw_next    = sw_reg;
    io_next    = io_reg;
    src_next   = src_reg;
    tw_next    = tw_reg;
    bank_next  = bank_reg;

    case (phase_reg)
      M1: io_next = io_op & ~sw_reg;
      M2: begin
        src_next = src_op & ~sw_reg;
        tw_next  = two_word & ~sw_reg;
      end
      X2: if (dcl_write && !sw_reg) bank_next = dcl_value;
      X3: if (!hold) begin
        // Cycle boundary: a latched two_word arms exactly one second-word
        // cycle (tw_reg is forced low during a second-word cycle).
        sw_next  = tw_reg & ~sw_reg;
        io_next  = 1'b0;
        src_next = 1'b0;
        tw_next  = 1'b0;
      end
      default: ;
    endcase

    cmd_next = (phase_next == A3) ||
               (phase_next == M2 && io_next) ||
               (phase_next == X2 && src_next);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      phase_reg   <= A1;
      sw_reg      <= 1'b0;
      io_reg      <= 1'b0;
      src_reg     <= 1'b0;
      tw_reg      <= 1'b0;
      bank_reg    <= 3'd0;
      sync_reg    <= 1'b0;
      addr_oe_reg <= 1'b1;
      ir_hi_reg   <= 1'b0;
      ir_lo_reg   <= 1'b0;
      pc_inc_reg  <= 1'b0;
      exec_en_reg <= 1'b0;
      cm_rom_reg  <= 1'b0;
      cm_ram_reg  <= 4'b0000;
    end else begin
      phase_reg   <= phase_next;
      sw_reg      <= sw_next;
      io_reg      <= io_next;
      src_reg     <= src_next;
      tw_reg      <= tw_next;
      bank_reg    <= bank_next;
      sync_reg    <= (phase_next == X3);
      addr_oe_reg <= (phase_next == A1) || (phase_next == A2) || (phase_next == A3);
      ir_hi_reg   <= (phase_next == M1);
      ir_lo_reg   <= (phase_next == M2);
      // A held X3 never re-enters A3, so this pulses once per cycle.
      pc_inc_reg  <= (phase_next == A3);
      exec_en_reg <= (phase_next >= X1) && !sw_next;
      cm_rom_reg  <= cmd_next;
      cm_ram_reg  <= cmd_next ? bank_pattern(bank_next) : 4'b0000;
    end
  end

  assign phase       = phase_reg;
  assign sync        = sync_reg;
  assign addr_oe     = addr_oe_reg;
  assign ir_hi_load  = ir_hi_reg;
  assign ir_lo_load  = ir_lo_reg;
  assign pc_inc      = pc_inc_reg;
  assign second_word = sw_reg;
  assign exec_en     = exec_en_reg;
  assign cm_rom      = cm_rom_reg;
  assign cm_ram      = cm_ram_reg;

endmodule

// File: tb/tb_bus_sequencer.sv
// Directed testbench for bus_sequencer. Expected values are hand-derived
// from the phase table; tb_ph tracks the phase the bench expects to be in.
module tb_bus_sequencer;

  logic       clock = 1'b0;
  logic       reset;
  logic       hold, io_op, src_op, two_word, dcl_write;
  logic [2:0] dcl_value;
  logic [2:0] phase;
  logic       sync, addr_oe, ir_hi_load, ir_lo_load, pc_inc;
  logic       second_word, exec_en, cm_rom;
  logic [3:0] cm_ram;

  int checks   = 0;
  int failures = 0;
  int tb_ph    = 0;
  int pc_cnt   = 0;
  int sync_cnt = 0;

  always #5 clock = ~clock;

  bus_sequencer dut (
    .clock       (clock),
    .reset       (reset),
    .hold        (hold),
    .io_op       (io_op),
    .src_op      (src_op),
    .two_word    (two_word),
    .dcl_write   (dcl_write),
    .dcl_value   (dcl_value),
    .phase       (phase),
    .sync        (sync),
    .addr_oe     (addr_oe),
    .ir_hi_load  (ir_hi_load),
    .ir_lo_load  (ir_lo_load),
    .pc_inc      (pc_inc),
    .second_word (second_word),
    .exec_en     (exec_en),
    .cm_rom      (cm_rom),
    .cm_ram      (cm_ram)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end else begin
      $display("check %s = %0d ok", tag, got);
    end
  endtask

  // One clock; outputs sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clock);
    if (!(tb_ph == 7 && hold)) tb_ph = (tb_ph + 1) % 8;
    #1;
  endtask

  task automatic advance_to(input int p);
    for (int n = 0; n < 9 && tb_ph != p; n++) tick();
    check_val("advance_phase", phase, p);
  endtask

  task automatic check_reset_vals(input string tag);
    check_val({tag, "_phase"},  phase, 0);
    check_val({tag, "_sync"},   sync, 0);
    check_val({tag, "_addroe"}, addr_oe, 1);
    check_val({tag, "_irhi"},   ir_hi_load, 0);
    check_val({tag, "_irlo"},   ir_lo_load, 0);
    check_val({tag, "_pcinc"},  pc_inc, 0);
    check_val({tag, "_sw"},     second_word, 0);
    check_val({tag, "_exec"},   exec_en, 0);
    check_val({tag, "_cmrom"},  cm_rom, 0);
    check_val({tag, "_cmram"},  cm_ram, 0);
  endtask

  initial begin
    reset = 1'b1; hold = 1'b0; io_op = 1'b0; src_op = 1'b0;
    two_word = 1'b0; dcl_write = 1'b0; dcl_value = 3'd0;

    // Reset state
    repeat (2) @(posedge clock);
    #2;
    check_reset_vals("rst");
    reset = 1'b0;
    tb_ph = 0;
    #1;

    // Free-running 16 clocks
    for (int k = 1; k <= 16; k++) begin
      tick();
      check_val("seq_phase", phase, k % 8);
      check_val("seq_sync", sync, (k % 8) == 7);
      check_val("seq_cmrom", cm_rom, (k % 8) == 2);
      check_val("seq_addroe", addr_oe, (k % 8) <= 2);
      check_val("seq_exec", exec_en, (k % 8) >= 5);
      check_val("seq_irhi", ir_hi_load, (k % 8) == 3);
      check_val("seq_irlo", ir_lo_load, (k % 8) == 4);
      pc_cnt += int'(pc_inc);
    end
    check_val("seq_pcinc_count", pc_cnt, 2);

    // DCL bank 3, then SRC in X2
    advance_to(6);
    dcl_write = 1'b1; dcl_value = 3'd3; tick();
    dcl_write = 1'b0; dcl_value = 3'd0;
    advance_to(2);
    check_val("dcl3_a3_cmrom", cm_rom, 1);
    check_val("dcl3_a3_cmram", cm_ram, 4'b0110);
    check_val("dcl3_a3_pcinc", pc_inc, 1);
    advance_to(4);
    check_val("noio_m2_cmrom", cm_rom, 0);
    src_op = 1'b1; tick(); src_op = 1'b0;
    check_val("src_x1_cmrom", cm_rom, 0);
    tick();
    check_val("src_x2_cmrom", cm_rom, 1);
    check_val("src_x2_cmram", cm_ram, 4'b0110);
    dcl_write = 1'b1; dcl_value = 3'd0; tick();
    dcl_write = 1'b0;
    advance_to(2);
    check_val("dcl0_a3_cmram", cm_ram, 4'b0001);
    advance_to(6);
    check_val("nosrc_x2_cmrom", cm_rom, 0);

    // Two-word instruction
    advance_to(4);
    two_word = 1'b1; tick(); two_word = 1'b0;
    check_val("tw_x1_sw", second_word, 0);
    check_val("tw_x1_exec", exec_en, 1);
    advance_to(0);
    check_val("sw_a1_sw", second_word, 1);
    check_val("sw_a1_exec", exec_en, 0);
    advance_to(2);
    check_val("sw_a3_pcinc", pc_inc, 1);
    advance_to(3);
    io_op = 1'b1; tick(); io_op = 1'b0;
    check_val("sw_m2_cmrom", cm_rom, 0);
    check_val("sw_m2_cmram", cm_ram, 0);
    two_word = 1'b1; tick(); two_word = 1'b0;
    check_val("sw_x1_exec", exec_en, 0);
    tick();
    check_val("sw_x2_exec", exec_en, 0);
    dcl_write = 1'b1; dcl_value = 3'd7; tick(); dcl_write = 1'b0; dcl_value = 3'd0;
    check_val("sw_x3_exec", exec_en, 0);
    check_val("sw_x3_sw", second_word, 1);
    tick();
    check_val("post_sw_a1_sw", second_word, 0);
    advance_to(2);
    check_val("sw_dcl_ignored", cm_ram, 4'b0001);
    advance_to(3);
    io_op = 1'b1; tick(); io_op = 1'b0;
    check_val("io_m2_cmrom", cm_rom, 1);
    check_val("io_m2_cmram", cm_ram, 4'b0001);
    advance_to(5);
    check_val("post_sw_exec", exec_en, 1);

    // Bank code 7
    advance_to(6);
    dcl_write = 1'b1; dcl_value = 3'd7; tick(); dcl_write = 1'b0; dcl_value = 3'd0;
    advance_to(2);
    check_val("dcl7_a3_cmram", cm_ram, 4'b1110);

    // Hold in X3
    advance_to(7);
    check_val("hold_entry_sync", sync, 1);
    sync_cnt = int'(sync);
    hold = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_val("hold_phase", phase, 7);
      check_val("hold_pcinc", pc_inc, 0);
      check_val("hold_cmrom", cm_rom, 0);
      sync_cnt += int'(sync);
    end
    hold = 1'b0;
    tick();
    check_val("hold_sync_count", sync_cnt, 6);
    check_val("release_phase", phase, 0);
    check_val("release_sync", sync, 0);

    // Reset pulse in M2 with two_word=1
    advance_to(4);
    two_word = 1'b1;
    #2 reset = 1'b1;
    #1 check_reset_vals("rst_m2");
    #1 reset = 1'b0; two_word = 1'b0; tb_ph = 0;
    tick();
    check_val("rst_m2_first_phase", phase, 1);
    advance_to(0);
    check_val("rst_m2_next_sw", second_word, 0);
    advance_to(2);
    check_val("rst_m2_bank", cm_ram, 4'b0001);

    // Reset during an armed second-word cycle
    advance_to(4);
    two_word = 1'b1; tick(); two_word = 1'b0;
    #2 reset = 1'b1;
    #1 reset = 1'b0; tb_ph = 0;
    check_val("rst_x1_sw", second_word, 0);
    advance_to(0);
    check_val("rst_x1_next_sw", second_word, 0);
    check_val("rst_x1_next_exec", exec_en, 0);
    advance_to(5);
    check_val("rst_x1_exec", exec_en, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
